uart_frame_parser: RTL

- Byte-stream deframer placed directly downstream of the UART receiver; consumes its 8-bit data word and single-cycle "byte done" pulse.
- Recognises frames of the form SYNC(0xAA), LEN, CMD, LEN payload bytes, CHK, where CHK = XOR of LEN, CMD and all payload bytes.
- Buffers the payload internally and exposes it to the command logic only after the checksum passes; reports length, checksum, timeout and overrun errors.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_frame_buf.sv | 27 ++
 rtl/uart_frame_parser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared states and constants for the UART frame parser
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_LEN,
        S_CMD,
        S_PAY,
        S_CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload register file, synchronous write, asynchronous read
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    // Contents survive reset; only the committed length says which bytes are meaningful.
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/CMD/payload/CHK deframer; FRAME_STATS_EN adds good/bad frame counters
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int  MAX_LEN     = 16,
    parameter int  TIMEOUT_CLK = 104160,
    localparam int AW          = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic [7:0]    frame_cmd,
    output logic [AW:0]   frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          overrun
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]   good_cnt,
    output logic [15:0]   bad_cnt
`endif
);

    localparam int         TW        = $clog2(TIMEOUT_CLK);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    chk_q, chk_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fvalid_q, fvalid_d;
    logic [7:0]    fcmd_q, fcmd_d;
    logic [AW:0]   flen_q, flen_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          ovr_q, ovr_d;
    logic          wr_en;
    logic          tmo_exp;

    // A byte landing in the expiry cycle wins over the timeout.
    assign tmo_exp = (state_q != IDLE) && !rx_valid && (tmo_q == TW'(TIMEOUT_CLK - 1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cmd_d    = cmd_q;
        chk_d    = chk_q;
        idx_d    = idx_q;
        fcmd_d   = fcmd_q;
        flen_d   = flen_q;
        fvalid_d = fvalid_q && !frame_ack;
        err_d    = 1'b0;
        code_d   = code_q;
        ovr_d    = 1'b0;
        wr_en    = 1'b0;
        tmo_d    = (state_q == IDLE || rx_valid) ? '0 : tmo_q + TW'(1);

        if (tmo_exp) begin
            state_d = IDLE;
            idx_d   = '0;
            tmo_d   = '0;
            err_d   = 1'b1;
            code_d  = ERR_TMO;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    // Registered frame_valid decides, so a byte beside frame_ack still overruns.
                    if (fvalid_q) begin
                        ovr_d = 1'b1;
                    end else if (rx_data == SYNC_BYTE) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_data > MAX_LEN_B) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else begin
                        len_d   = rx_data[AW:0];
                        chk_d   = rx_data;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_d   = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    idx_d   = '0;
                    state_d = (len_q == '0) ? S_CHK : S_PAY;
                end
                S_PAY: begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + AW'(1);
                    if ({1'b0, idx_q} == len_q - (AW + 1)'(1)) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_data == chk_q) begin
                        fcmd_d   = cmd_q;
                        flen_d   = len_q;
                        fvalid_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                    idx_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cmd_q    <= '0;
            chk_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            fvalid_q <= 1'b0;
            fcmd_q   <= '0;
            flen_q   <= '0;
            err_q    <= 1'b0;
            code_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cmd_q    <= cmd_d;
            chk_q    <= chk_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            fvalid_q <= fvalid_d;
            fcmd_q   <= fcmd_d;
            flen_q   <= flen_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_valid = fvalid_q;
    assign frame_cmd   = fcmd_q;
    assign frame_len   = flen_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign overrun     = ovr_q;

`ifdef FRAME_STATS_EN
    logic [15:0] good_q;
    logic [15:0] bad_q;

    // A rising frame_valid is exactly a commit; overruns never reach err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (fvalid_d && !fvalid_q && good_q != 16'hFFFF) begin
                good_q <= good_q + 16'd1;
            end
            if (err_d && bad_q != 16'hFFFF) begin
                bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule
